// File: rtl/spi_mem_bridge_if.sv
// Request/response bus between the core's memory-access FSM and the SPI SRAM bridge.
interface spi_mem_bridge_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              req_ready;
  logic              busy;
  logic              done;
  logic [7:0]        rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, busy, done, rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, busy, done, rdata
  );
endinterface

// File: rtl/spi_mem_bridge.sv
// Single-byte core memory access -> one SPI mode-0 transaction to a 23LC-style SRAM.
// Optional SPI_MEM_CACHE_EN: one-entry last-access cache that short-circuits read hits.
module spi_mem_bridge #(
  parameter int ADDR_W  = 8,
  parameter int CLK_DIV = 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  spi_mem_bridge_if.slave        bus,
  output logic                   spi_cs_n,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic [31:0]   sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          wr_q, wr_d;
  logic [15:0]   addr16;

  assign addr16 = 16'(bus.req_addr);

`ifdef SPI_MEM_CACHE_EN
  logic              tag_valid_q, tag_valid_d;
  logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
  logic [7:0]        tag_data_q, tag_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
`ifdef SPI_MEM_CACHE_EN
    tag_valid_d = tag_valid_q;
    tag_addr_d  = tag_addr_q;
    tag_data_d  = tag_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          sh_d    = {bus.req_write ? 8'h02 : 8'h03, addr16,
                     bus.req_write ? bus.req_wdata : 8'h00};
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
`ifdef SPI_MEM_CACHE_EN
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (!bus.req_write && tag_valid_q && tag_addr_q == bus.req_addr) begin
            state_d = DONE;
            rdata_d = tag_data_q;
          end
`endif
        end
      end
      SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if (!sclk_q) begin
            // rising sclk edge: sample; the rx window naturally keeps the last 8 bits
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            sh_d   = {sh_q[30:0], 1'b0};
            if (bit_q == 5'd31) begin
              state_d = DONE;
              if (!wr_q) rdata_d = rx_q;
`ifdef SPI_MEM_CACHE_EN
              tag_valid_d = 1'b1;
              tag_addr_d  = addr_q;
              tag_data_d  = wr_q ? wdata_q : rx_q;
`endif
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      sh_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

`ifdef SPI_MEM_CACHE_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tag_valid_q <= 1'b0;
      tag_addr_q  <= '0;
      tag_data_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_addr_q  <= tag_addr_d;
      tag_data_q  <= tag_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end
`endif

  // Pin outputs decode straight from reset flops so an async reset takes effect at once.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.rdata     = rdata_q;
  assign spi_cs_n      = (state_q != SHIFT);
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = (state_q == SHIFT) & sh_q[31];

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Scoreboard bench: two bridges (CLK_DIV 1 and 2) share one behavioural SPI SRAM via a select mux.
module tb_spi_mem_bridge;

`ifdef SPI_MEM_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       spi_miso = 1'b0;
  logic       cs1, sclk1, mosi1, cs2, sclk2, mosi2;
  logic       spi_cs_n, spi_sclk, spi_mosi, ready, done, busy;
  logic [7:0] rdata;

  spi_mem_bridge_if #(.ADDR_W(8)) m1 ();
  spi_mem_bridge_if #(.ADDR_W(8)) m2 ();

  assign m1.req_valid = req_valid & ~sel;
  assign m2.req_valid = req_valid & sel;
  assign m1.req_write = req_write;
  assign m2.req_write = req_write;
  assign m1.req_addr  = req_addr;
  assign m2.req_addr  = req_addr;
  assign m1.req_wdata = req_wdata;
  assign m2.req_wdata = req_wdata;

  spi_mem_bridge #(.ADDR_W(8), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .nreset(nreset), .bus(m1),
    .spi_cs_n(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(spi_miso));

  spi_mem_bridge #(.ADDR_W(8), .CLK_DIV(2)) u_dut2 (
    .clk(clk), .nreset(nreset), .bus(m2),
    .spi_cs_n(cs2), .spi_sclk(sclk2), .spi_mosi(mosi2), .spi_miso(spi_miso));

  assign spi_cs_n = sel ? cs2 : cs1;
  assign spi_sclk = sel ? sclk2 : sclk1;
  assign spi_mosi = sel ? mosi2 : mosi1;
  assign ready    = sel ? m2.req_ready : m1.req_ready;
  assign done     = sel ? m2.done : m1.done;
  assign busy     = sel ? m2.busy : m1.busy;
  assign rdata    = sel ? m2.rdata : m1.rdata;

  // Behavioural 23LC SRAM: READ 0x03 / WRITE 0x02, 16-bit address, low byte used.
  logic [7:0]  mem [256];
  int          scnt;
  logic [31:0] sin, last_frame;
  logic [7:0]  sout;
  int          wr_count = 0;

  always @(negedge spi_cs_n) begin
    scnt = 0;
    sin  = '0;
    spi_miso = 1'b0;
  end

  always @(posedge spi_sclk) begin
    if (!spi_cs_n) begin
      sin = {sin[30:0], spi_mosi};
      scnt++;
      if (scnt == 32) begin
        last_frame = sin;
        if (sin[31:24] == 8'h02) begin
          mem[sin[15:8]] = sin[7:0];
          wr_count++;
        end
      end
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_cs_n && scnt >= 24 && scnt < 32) begin
      if (scnt == 24) sout = mem[sin[7:0]];
      spi_miso = sout[7];
      sout = {sout[6:0], 1'b0};
    end
  end

  // Scoreboard
  typedef struct {
    logic [7:0]  rdata;
    int          lat;
    int          cslow;
    bit          cf;
    logic [31:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   cs_low = 0, last_done = 0, fall_gap = 0;
  logic prev_cs = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  always @(negedge clk) begin
    if (nreset) begin
      if (!spi_cs_n) cs_low++;
      if (prev_cs && !spi_cs_n) fall_gap = cyc - last_done;
      prev_cs = spi_cs_n;
      if (req_valid && ready) begin
        acc_q.push_back(cyc);
        cs_low = 0;
      end
      if (done) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("latency", cyc - a, e.lat);
          chk("cs_low_cycles", cs_low, e.cslow);
          if (e.cf) chk("mosi_frame", last_frame, e.frame);
        end
        last_done = cyc;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("done_timeout");
      exp_q.delete();
    end
  endtask

  task automatic push_exp(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] er, input int lat, input int csl, input bit cf);
    exp_t e;
    e.rdata = er; e.lat = lat; e.cslow = csl; e.cf = cf;
    e.frame = {wr ? 8'h02 : 8'h03, 8'h00, a, wr ? wd : 8'h00};
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit s, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] er, input int lat, input int csl, input bit cf);
    sel = s;
    wait_ready();
    if (!ready) begin
      fail_now("ready_timeout");
      return;
    end
    push_exp(wr, a, wd, er, lat, csl, cf);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // garbage after accept must not reach the SRAM
    req_valid = 1'b0; req_write = ~wr; req_addr = 8'hEE; req_wdata = 8'hEE;
    wait_drain();
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h05] = 8'hA5; mem[8'hFF] = 8'hC3; mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22; mem[8'h07] = 8'h5A; mem[8'h40] = 8'h77;

    #1 nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", cs1, 1'b1);
    chk("rst_sclk", sclk1, 1'b0);
    nreset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mosi", mosi1, 1'b0);
    chk("rst_done", m1.done, 1'b0);
    chk("rst_busy", m1.busy, 1'b0);
    chk("rst_ready", m1.req_ready, 1'b1);
    chk("rst_rdata", m1.rdata, 8'h00);

    issue(0, 0, 8'h05, 8'h00, 8'hA5, 65, 64, 1);
    issue(0, 1, 8'h12, 8'h3C, 8'hA5, 65, 64, 1);
    chk("sram_wr_12", mem[8'h12], 8'h3C);
    // the write loads the tag, so this readback is a cache hit when enabled
    issue(0, 0, 8'h12, 8'h00, 8'h3C, CACHE ? 1 : 65, CACHE ? 0 : 64, !CACHE);

    issue(1, 0, 8'hFF, 8'h00, 8'hC3, 129, 128, 1);

    // back-to-back reads with req_valid held high
    sel = 0;
    wait_ready();
    push_exp(0, 8'h01, 8'h00, 8'h11, 65, 64, 1);
    push_exp(0, 8'h02, 8'h00, 8'h22, 65, 64, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h01;
    @(posedge clk); #1;
    req_addr = 8'h02;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();
    chk("b2b_cs_gap", fall_gap, 3);

    issue(0, 0, 8'h07, 8'h00, 8'h5A, 65, 64, 1);
    issue(0, 0, 8'h07, 8'h00, 8'h5A, CACHE ? 1 : 65, CACHE ? 0 : 64, !CACHE);
    issue(0, 1, 8'h07, 8'h11, 8'h5A, 65, 64, 1);
    issue(0, 0, 8'h07, 8'h00, 8'h11, CACHE ? 1 : 65, CACHE ? 0 : 64, !CACHE);
    chk("sram_wr_07", mem[8'h07], 8'h11);

    // reset in the middle of a write: aborted, no done, SRAM untouched
    sel = 0;
    wait_ready();
    begin
      int wc;
      wc = wr_count;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 8'h99;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (19) @(posedge clk);
      #2 nreset = 1'b0;
      #1;
      chk("midrst_cs_n", cs1, 1'b1);
      chk("midrst_sclk", sclk1, 1'b0);
      chk("midrst_done", m1.done, 1'b0);
      @(posedge clk); #1;
      nreset = 1'b1;
      acc_q.delete();
      @(posedge clk); #1;
      chk("midrst_ready", m1.req_ready, 1'b1);
      chk("midrst_rdata", m1.rdata, 8'h00);
      chk("midrst_wr_count", wr_count, wc);
      chk("midrst_sram_40", mem[8'h40], 8'h77);
    end

    // reset also clears the tag, so this goes over SPI again
    issue(0, 0, 8'h07, 8'h00, 8'h11, 65, 64, 1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
